bus_transfer_reader: RTL
========================

BUS_TRANSFER_READER -- requirements
Module: bus_transfer_reader

Interface
REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the width of each register value and of the bus.
REQ-002: Parameter NUM_REGS, default 8, SHALL set the number of source/destination registers (2..16).
REQ-003: Parameter SEL_W, default 3, SHALL set the index width, with 2**SEL_W >= NUM_REGS.
REQ-004: The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005: clock  in  1  rising-edge clock.
REQ-006: clear  in  1  asynchronous active-low reset.
REQ-007: req_valid  in  1  transfer request present.
REQ-008: req_ready  out  1  block can accept a request.
REQ-009: req_src  in  SEL_W  source register index.
REQ-010: req_dst  in  SEL_W  destination register index.
REQ-011: src_data  in  NUM_REGS*DATA_WIDTH  all register outputs; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012: BusMuxOut  out  DATA_WIDTH  registered bus value presented to register inputs.
REQ-013: reg_enable  out  NUM_REGS  one-hot write enable, bit i enables register i.
REQ-014: done  out  1  one-cycle transfer-complete pulse.
REQ-015: err  out  1  one-cycle pulse, coincident with done, for a rejected transfer.
REQ-016: xfer_count  out  8  count of successful transfers.

Function
REQ-017: The FSM SHALL have states IDLE, SELECT, WRITE and DONE.
REQ-018: req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-019: On acceptance the block SHALL latch req_src and req_dst and move IDLE->SELECT; changes to req_* after acceptance SHALL have no effect.
REQ-020: In SELECT the block SHALL load BusMuxOut with the latched source's slice of src_data at the next edge and move to WRITE.
REQ-021: In WRITE, reg_enable SHALL have exactly the latched destination bit set for exactly one cycle, and the state SHALL move to DONE.
REQ-022: In DONE, done SHALL be 1 for one cycle, xfer_count SHALL increment, and the state SHALL return to IDLE.
REQ-023: Timing, with acceptance at edge k:
  - BusMuxOut valid after edge k+1;
  - reg_enable high between edges k+1 and k+2;
  - done high between edges k+2 and k+3;
  - req_ready high again after edge k+3.
REQ-024: Maximum throughput SHALL be one transfer per 4 cycles.
REQ-025: If req_src >= NUM_REGS or req_dst >= NUM_REGS, the block SHALL go SELECT->DONE with BusMuxOut unchanged and reg_enable all 0. done and err SHALL both pulse, and xfer_count SHALL NOT increment.
REQ-026: req_src == req_dst SHALL be legal; the register is rewritten with its own value.
REQ-027: xfer_count SHALL wrap from 255 to 0.
REQ-028: BusMuxOut SHALL hold its last value in every state except the SELECT->WRITE load.
REQ-029: reg_enable SHALL be all 0 outside WRITE.
REQ-030: done and err SHALL be 0 outside DONE.

Reset
REQ-031: clear=0 SHALL immediately (asynchronously) force state IDLE, BusMuxOut=0, reg_enable=0, done=0, err=0 and xfer_count=0; req_ready SHALL be 1 once clear=1.
REQ-032: Asserting clear mid-transfer SHALL abort the transfer with no enable pulse afterwards; the first edge after release SHALL be able to accept a new request.

Verification
REQ-033: Single transfer: reg3=0xA5, request src=3 dst=5 -> BusMuxOut=0xA5 after edge k+1; reg_enable=8'b0010_0000 for one cycle; done one cycle later; xfer_count=1.
REQ-034: Back-to-back: req_valid held high with two requests -> second accepted exactly 4 cycles after the first; req_ready=0 during SELECT, WRITE and DONE.
REQ-035: Out-of-range with NUM_REGS=6: src=7 -> err and done pulse together; reg_enable stays 0; BusMuxOut unchanged; xfer_count unchanged.
REQ-036: Reset mid-op: clear=0 during WRITE -> reg_enable=0 immediately; BusMuxOut=0; xfer_count=0; no done pulse.
REQ-037: Wrap: 256 successful transfers -> xfer_count reads 0.
REQ-038: Self-transfer: src=dst=2 with reg2=0x3C -> reg_enable=8'b0000_0100; BusMuxOut=0x3C; done pulses.

Source files
------------

// File: rtl/bus_transfer_reader.sv
// rtl/bus_transfer_reader.sv - register-to-register bus transfer sequencer
module bus_transfer_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int SEL_W      = 3
) (
    input  logic                           clock,
    input  logic                           clear,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SEL_W-1:0]               req_src,
    input  logic [SEL_W-1:0]               req_dst,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0]          BusMuxOut,
    output logic [NUM_REGS-1:0]            reg_enable,
    output logic                           done,
    output logic                           err,
    output logic [7:0]                     xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_REGS);

    state_t                  state;
    state_t                  state_nxt;
    logic [SEL_W-1:0]        src_q;
    logic [SEL_W-1:0]        dst_q;
    logic                    bad_q;
    logic                    req_bad;
    logic [DATA_WIDTH-1:0]   sel_data;

    // An index outside the register file turns the request into an error transfer
    assign req_bad = ({1'b0, req_src} >= LIMIT) || ({1'b0, req_dst} >= LIMIT);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_W'(i)) begin
                sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            bad_q      <= 1'b0;
            BusMuxOut  <= '0;
            xfer_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_valid) begin
                src_q <= req_src;
                dst_q <= req_dst;
                bad_q <= req_bad;
            end
            if (state == S_SELECT && !bad_q) begin
                BusMuxOut <= sel_data;
            end
            if (state == S_DONE && !bad_q) begin
                xfer_count <= xfer_count + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        reg_enable = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                state_nxt = bad_q ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    reg_enable[i] = (dst_q == SEL_W'(i));
                end
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                err       = bad_q;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
